// File: rtl/ipsmacge_mapautmr.sv
// Transmit pause timer: turns received pause quanta into a maclk-cycle hold
// interval, deferring its start until any in-progress frame completes.
module ipsmacge_mapautmr #(
    parameter int QCLK = 64,
    parameter int QW   = 6
) (
    input  logic        marst_,
    input  logic        maclk,
    input  logic        ipauvld,
    input  logic [15:0] ipauqua,
    input  logic        pauen,
    input  logic        txbusy,
    input  logic        cntclr,
    output logic        txhold,
    output logic        pauact,
    output logic [15:0] pauremain,
    output logic [15:0] paucnt
);

    typedef enum logic [1:0] {IDLE, WAIT, PAUSE} state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   subcnt_q, subcnt_d;
    logic [15:0]     rem_q, rem_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            vld_q;
    logic [15:0]     qua_q;
    logic            txhold_q, pauact_q;

    logic            ld;
    logic            qua_zero;
    logic            qtick;

    // A held valid only reloads when back-to-back frames change the quanta.
    assign ld       = pauen & ipauvld & (~vld_q | (ipauqua != qua_q));
    assign qua_zero = (ipauqua == 16'd0);
    assign qtick    = (state_q == PAUSE) && (subcnt_q == QW'(QCLK - 1));

    always_comb begin
        state_d  = state_q;
        subcnt_d = subcnt_q;
        rem_d    = rem_q;
        if (!pauen) begin
            state_d  = IDLE;
            subcnt_d = '0;
            rem_d    = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld && !qua_zero) begin
                        state_d  = txbusy ? WAIT : PAUSE;
                        rem_d    = ipauqua;
                        subcnt_d = '0;
                    end
                end
                WAIT: begin
                    if (ld) begin
                        if (qua_zero) begin
                            state_d = IDLE;
                            rem_d   = 16'd0;
                        end else begin
                            state_d = txbusy ? WAIT : PAUSE;
                            rem_d   = ipauqua;
                        end
                        subcnt_d = '0;
                    end else if (!txbusy) begin
                        state_d  = PAUSE;
                        subcnt_d = '0;
                    end
                end
                PAUSE: begin
                    // Sub-counter width equals log2(QCLK), so it wraps on its own.
                    subcnt_d = subcnt_q + {{(QW-1){1'b0}}, 1'b1};
                    if (ld) begin
                        subcnt_d = '0;
                        if (qua_zero) begin
                            state_d = IDLE;
                            rem_d   = 16'd0;
                        end else begin
                            rem_d = ipauqua;
                        end
                    end else if (qtick) begin
                        if (rem_q <= 16'd1) begin
                            state_d = IDLE;
                            rem_d   = 16'd0;
                        end else begin
                            rem_d = rem_q - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    subcnt_d = '0;
                    rem_d    = 16'd0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cntclr)
            cnt_d = 16'd0;
        else if (ld && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge maclk or negedge marst_) begin
        if (!marst_) begin
            state_q  <= IDLE;
            subcnt_q <= '0;
            rem_q    <= 16'd0;
            cnt_q    <= 16'd0;
            vld_q    <= 1'b0;
            qua_q    <= 16'd0;
            txhold_q <= 1'b0;
            pauact_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            subcnt_q <= subcnt_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            vld_q    <= ipauvld;
            qua_q    <= ipauqua;
            txhold_q <= (state_d != IDLE);
            pauact_q <= (state_d == PAUSE);
        end
    end

    assign txhold    = txhold_q;
    assign pauact    = pauact_q;
    assign pauremain = rem_q;
    assign paucnt    = cnt_q;

endmodule

// File: tb/tb_ipsmacge_mapautmr.sv
// Bench for the transmit pause timer: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is observed.
module tb_ipsmacge_mapautmr;

    localparam int QCLK = 64;
    localparam int QW   = 6;

    logic        marst_;
    logic        maclk;
    logic        ipauvld;
    logic [15:0] ipauqua;
    logic        pauen;
    logic        txbusy;
    logic        cntclr;
    logic        txhold;
    logic        pauact;
    logic [15:0] pauremain;
    logic [15:0] paucnt;

    int checks = 0;
    int fails  = 0;
    logic [31:0] sb[$];

    ipsmacge_mapautmr #(.QCLK(QCLK), .QW(QW)) dut (
        .marst_    (marst_),
        .maclk     (maclk),
        .ipauvld   (ipauvld),
        .ipauqua   (ipauqua),
        .pauen     (pauen),
        .txbusy    (txbusy),
        .cntclr    (cntclr),
        .txhold    (txhold),
        .pauact    (pauact),
        .pauremain (pauremain),
        .paucnt    (paucnt)
    );

    initial maclk = 1'b0;
    always #5 maclk = ~maclk;

    task automatic step();
        @(posedge maclk);
        #1;
    endtask

    task automatic do_reset();
        marst_  = 1'b0;
        ipauvld = 1'b0;
        ipauqua = 16'd0;
        pauen   = 1'b0;
        txbusy  = 1'b0;
        cntclr  = 1'b0;
        step();
        step();
        marst_ = 1'b1;
        step();
    endtask

    // Issues one load with quanta q and runs until txhold falls (bounded).
    task automatic hold_run(input logic [15:0] q, input int vldlen, input int busylen,
                            output int hold_n, output int wait_n,
                            output logic [15:0] r0, output logic [15:0] r1,
                            output logic [15:0] r2);
        int k;
        ipauqua = q;
        ipauvld = 1'b1;
        txbusy  = (busylen > 0);
        step();
        k = 0; hold_n = 0; wait_n = 0;
        r0 = 16'hDEAD; r1 = 16'hDEAD; r2 = 16'hDEAD;
        while (txhold && k < 5000) begin
            hold_n++;
            if (!pauact) wait_n++;
            if (k == 0)        r0 = pauremain;
            if (k == QCLK)     r1 = pauremain;
            if (k == 2 * QCLK) r2 = pauremain;
            if (k + 1 >= vldlen)  ipauvld = 1'b0;
            if (k == busylen - 1) txbusy = 1'b0;
            k++;
            step();
        end
        ipauvld = 1'b0;
        txbusy  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset();
        sb.push_back(32'd0);
        e = sb.pop_front();
        checks++;
        if ({txhold, pauact, pauremain, paucnt} !== e[0 +: 1] ? 1'b1 : 1'b0) begin end
        if ({txhold, pauact, pauremain, paucnt} !== {2'b00, e[15:0], e[31:16]}) begin
            $display("FAIL reset: got txhold=%0b pauact=%0b rem=%0d cnt=%0d, want all 0",
                     txhold, pauact, pauremain, paucnt);
            fails++;
        end
    endtask

    task automatic test_basic_pause();
        int hold_n, wait_n;
        logic [15:0] r0, r1, r2;
        logic [31:0] e;
        do_reset();
        pauen = 1'b1;
        sb.push_back(32'd192); sb.push_back(32'd0);
        sb.push_back(32'd3); sb.push_back(32'd2); sb.push_back(32'd1);
        sb.push_back(32'd0); sb.push_back(32'd1);
        hold_run(16'd3, 4, 0, hold_n, wait_n, r0, r1, r2);
        e = sb.pop_front(); checks++;
        if (hold_n !== int'(e)) begin $display("FAIL basic_hold: got %0d want %0d", hold_n, e); fails++; end
        e = sb.pop_front(); checks++;
        if (wait_n !== int'(e)) begin $display("FAIL basic_pauact: got %0d cycles without pauact want %0d", wait_n, e); fails++; end
        e = sb.pop_front(); checks++;
        if (r0 !== e[15:0]) begin $display("FAIL basic_rem0: got %0d want %0d", r0, e); fails++; end
        e = sb.pop_front(); checks++;
        if (r1 !== e[15:0]) begin $display("FAIL basic_rem1: got %0d want %0d", r1, e); fails++; end
        e = sb.pop_front(); checks++;
        if (r2 !== e[15:0]) begin $display("FAIL basic_rem2: got %0d want %0d", r2, e); fails++; end
        e = sb.pop_front(); checks++;
        if (pauremain !== e[15:0]) begin $display("FAIL basic_rem_end: got %0d want %0d", pauremain, e); fails++; end
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL basic_cnt: got %0d want %0d", paucnt, e); fails++; end
    endtask

    task automatic test_wait_busy();
        int hold_n, wait_n;
        logic [15:0] r0, r1, r2;
        logic [31:0] e;
        do_reset();
        pauen = 1'b1;
        sb.push_back(32'd100); sb.push_back(32'd228);
        hold_run(16'd2, 1, 100, hold_n, wait_n, r0, r1, r2);
        e = sb.pop_front(); checks++;
        if (wait_n !== int'(e)) begin $display("FAIL wait_len: got %0d want %0d", wait_n, e); fails++; end
        e = sb.pop_front(); checks++;
        if (hold_n !== int'(e)) begin $display("FAIL wait_hold: got %0d want %0d", hold_n, e); fails++; end
    endtask

    task automatic test_restart_xon();
        int n;
        logic [31:0] e;
        do_reset();
        pauen   = 1'b1;
        ipauqua = 16'd8; ipauvld = 1'b1; step(); ipauvld = 1'b0;
        n = 0;
        while (pauremain != 16'd5 && n < 1000) begin n++; step(); end
        checks++;
        if (n >= 1000) begin $display("FAIL restart_reach5: timeout, rem=%0d want 5", pauremain); fails++; end
        repeat (20) step();
        sb.push_back(32'd10); sb.push_back(32'd640);
        ipauqua = 16'd10; ipauvld = 1'b1; step(); ipauvld = 1'b0;
        e = sb.pop_front(); checks++;
        if (pauremain !== e[15:0]) begin $display("FAIL restart_reload: got %0d want %0d", pauremain, e); fails++; end
        n = 0;
        while (txhold && n < 5000) begin n++; step(); end
        e = sb.pop_front(); checks++;
        if (n !== int'(e)) begin $display("FAIL restart_hold: got %0d want %0d", n, e); fails++; end
        ipauqua = 16'd5; ipauvld = 1'b1; step(); ipauvld = 1'b0;
        repeat (10) step();
        sb.push_back(32'd0); sb.push_back(32'd4);
        ipauqua = 16'd0; ipauvld = 1'b1; step();
        e = sb.pop_front(); checks++;
        if ({pauremain, 15'd0, txhold} !== {e[15:0], 15'd0, e[0]}) begin
            $display("FAIL xon: got txhold=%0b rem=%0d want 0/0", txhold, pauremain); fails++;
        end
        ipauvld = 1'b0; step();
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL xon_cnt: got %0d want %0d", paucnt, e); fails++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        do_reset();
        pauen = 1'b1;
        sb.push_back(32'd1); sb.push_back(32'd6); sb.push_back(32'd2);
        ipauqua = 16'd4; ipauvld = 1'b1;
        repeat (6) step();
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL b2b_same: got cnt %0d want %0d", paucnt, e); fails++; end
        ipauqua = 16'd6; step();
        e = sb.pop_front(); checks++;
        if (pauremain !== e[15:0]) begin $display("FAIL b2b_reload: got %0d want %0d", pauremain, e); fails++; end
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL b2b_cnt: got %0d want %0d", paucnt, e); fails++; end
        ipauvld = 1'b0; step();
    endtask

    task automatic test_pauen();
        logic [31:0] e;
        do_reset();
        pauen = 1'b1;
        ipauqua = 16'd3; ipauvld = 1'b1; step(); ipauvld = 1'b0;
        repeat (50) step();
        sb.push_back(32'd0); sb.push_back(32'd1); sb.push_back(32'd0);
        pauen = 1'b0; step();
        e = sb.pop_front(); checks++;
        if ({txhold, pauact, pauremain} !== {2'b00, e[15:0]}) begin
            $display("FAIL pauen_off: got txhold=%0b pauact=%0b rem=%0d want 0", txhold, pauact, pauremain); fails++;
        end
        ipauqua = 16'd7; ipauvld = 1'b1; step(); step();
        e = sb.pop_front(); checks++;
        if ({txhold, paucnt} !== {1'b0, e[15:0]}) begin
            $display("FAIL pauen_ignore: got txhold=%0b cnt=%0d want 0/%0d", txhold, paucnt, e); fails++;
        end
        ipauvld = 1'b0; step(); pauen = 1'b1; step(); step();
        e = sb.pop_front(); checks++;
        if (txhold !== e[0]) begin $display("FAIL pauen_reenable: got txhold=%0b want %0b", txhold, e[0]); fails++; end
    endtask

    task automatic test_saturate_reset();
        logic [31:0] e;
        do_reset();
        pauen = 1'b1; ipauvld = 1'b1;
        sb.push_back(32'hFFFE); sb.push_back(32'hFFFF); sb.push_back(32'd0); sb.push_back(32'd0);
        for (int i = 0; i < 65534; i++) begin
            ipauqua = (i % 2 == 1) ? 16'd2 : 16'd1;
            step();
        end
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL sat_pre: got %h want %h", paucnt, e[15:0]); fails++; end
        for (int i = 0; i < 3; i++) begin
            ipauqua = (ipauqua == 16'd1) ? 16'd2 : 16'd1;
            step();
        end
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL sat_hold: got %h want %h", paucnt, e[15:0]); fails++; end
        ipauqua = (ipauqua == 16'd1) ? 16'd2 : 16'd1;
        cntclr = 1'b1; step(); cntclr = 1'b0;
        e = sb.pop_front(); checks++;
        if (paucnt !== e[15:0]) begin $display("FAIL sat_clr: got %h want %h", paucnt, e[15:0]); fails++; end
        ipauvld = 1'b0; step();
        ipauqua = 16'd3; ipauvld = 1'b1; step(); ipauvld = 1'b0;
        repeat (30) step();
        marst_ = 1'b0; #1;
        e = sb.pop_front(); checks++;
        if ({txhold, pauact, pauremain, paucnt} !== {2'b00, e[15:0], e[15:0]}) begin
            $display("FAIL async_reset: got txhold=%0b pauact=%0b rem=%0d cnt=%0d want all 0",
                     txhold, pauact, pauremain, paucnt); fails++;
        end
        step();
        marst_ = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_pause();
        test_wait_busy();
        test_restart_xon();
        test_back_to_back();
        test_pauen();
        test_saturate_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
